// File: rtl/scroll_v_ctrl_if.sv
// Bus between the vertical-scroll controller and its neighbours: debounced controls in, scroll state out.
// score_bcd exists only when SCROLL_BCD_EN is defined.
interface scroll_v_ctrl_if #(
    parameter int Y_W     = 10,
    parameter int SCORE_W = 7,
    parameter int LVL_W   = 2
);
    logic               move_btn;
    logic               pause;
    logic [Y_W-1:0]     y_pos;
    logic [SCORE_W-1:0] score;
    logic [LVL_W-1:0]   level;
    logic               move_followers;
    logic               wrap;
    logic [1:0]         run_state;
`ifdef SCROLL_BCD_EN
    logic [7:0]         score_bcd;
`endif

    modport master (
`ifdef SCROLL_BCD_EN
        input  score_bcd,
`endif
        output move_btn, pause,
        input  y_pos, score, level, move_followers, wrap, run_state
    );

    modport slave (
`ifdef SCROLL_BCD_EN
        output score_bcd,
`endif
        input  move_btn, pause,
        output y_pos, score, level, move_followers, wrap, run_state
    );
endinterface

// File: rtl/scroll_v_ctrl.sv
// Vertical-scroll controller: level-dependent stepping of y_pos per tick, modular wrap, saturating score and level.
// Optional feature macro SCROLL_BCD_EN adds a registered BCD copy of the score on the bus.
module scroll_v_ctrl #(
    parameter int Y_W            = 10,
    parameter int SCREEN_HEIGHT  = 480,
    parameter int TICK_CYCLES    = 100000,
    parameter int SCORE_TICKS    = 100,
    parameter int SCORE_W        = 7,
    parameter int SCORE_MAX      = 99,
    parameter int STEP_MIN       = 1,
    parameter int STEP_MAX       = 4,
    parameter int LEVEL_UP_SCORE = 10,
    parameter int LVL_W          = 2
) (
    input  logic           clk,
    input  logic           reset,
    scroll_v_ctrl_if.slave bus
);
    localparam int CTR_W = $clog2(TICK_CYCLES);
    localparam int TCK_W = (SCORE_TICKS > 1) ? $clog2(SCORE_TICKS) : 1;
    localparam int LC_W  = (LEVEL_UP_SCORE > 1) ? $clog2(LEVEL_UP_SCORE) : 1;

    localparam logic [CTR_W-1:0]   CTR_LAST      = CTR_W'(TICK_CYCLES - 1);
    localparam logic [TCK_W-1:0]   TICK_LAST     = TCK_W'(SCORE_TICKS - 1);
    localparam logic [LC_W-1:0]    LVL_CNT_LAST  = LC_W'(LEVEL_UP_SCORE - 1);
    localparam logic [SCORE_W-1:0] SCORE_CEIL    = SCORE_W'(SCORE_MAX);
    localparam logic [LVL_W-1:0]   LVL_CEIL      = LVL_W'(STEP_MAX - STEP_MIN);
    localparam logic [Y_W:0]       HEIGHT_EXT    = (Y_W + 1)'(SCREEN_HEIGHT);
    localparam logic [Y_W:0]       STEP_BASE_EXT = (Y_W + 1)'(STEP_MIN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    state_t             state_r;
    logic [CTR_W-1:0]   ctr_r;
    logic [TCK_W-1:0]   tick_cnt_r;
    logic [LC_W-1:0]    lvl_cnt_r;
    logic [Y_W-1:0]     y_pos_r;
    logic [SCORE_W-1:0] score_r;
    logic [LVL_W-1:0]   level_r;
    logic               move_followers_r;
    logic               wrap_r;

    logic               run_s;
    logic               tick_s;
    logic               point_s;
    logic               grow_s;
    logic               lvl_wrap_s;
    logic [Y_W:0]       step_s;
    logic [Y_W:0]       sum_s;
    logic               wrap_s;
    logic [Y_W-1:0]     y_next_s;

    // Tick/score qualifiers and the next scroll offset with modular wrap
    always_comb begin
        run_s      = bus.move_btn & ~bus.pause;
        tick_s     = run_s & (ctr_r == CTR_LAST);
        point_s    = tick_s & (tick_cnt_r == TICK_LAST);
        grow_s     = point_s & (score_r < SCORE_CEIL);
        lvl_wrap_s = (lvl_cnt_r == LVL_CNT_LAST);
        step_s     = STEP_BASE_EXT + (Y_W + 1)'(level_r);
        sum_s      = {1'b0, y_pos_r} + step_s;
        wrap_s     = (sum_s >= HEIGHT_EXT);
        y_next_s   = sum_s[Y_W-1:0];
        if (wrap_s) begin
            y_next_s = Y_W'(sum_s - HEIGHT_EXT);
        end else begin
            y_next_s = sum_s[Y_W-1:0];
        end
    end

    // Mode tracking; counters key off the live RUN condition, this register reports the settled mode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else if (bus.pause) begin
            state_r <= ST_PAUSE;
        end else begin
            case (state_r)
                ST_IDLE:  state_r <= bus.move_btn ? ST_RUN : ST_IDLE;
                ST_RUN:   state_r <= bus.move_btn ? ST_RUN : ST_HOLD;
                ST_HOLD:  state_r <= bus.move_btn ? ST_RUN : ST_HOLD;
                ST_PAUSE: state_r <= bus.move_btn ? ST_RUN : ST_HOLD;
                default:  state_r <= ST_IDLE;
            endcase
        end
    end

    // Tick period counter, scroll position and the per-tick pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctr_r            <= '0;
            tick_cnt_r       <= '0;
            y_pos_r          <= '0;
            move_followers_r <= 1'b0;
            wrap_r           <= 1'b0;
        end else begin
            move_followers_r <= tick_s;
            wrap_r           <= tick_s & wrap_s;
            if (tick_s) begin
                ctr_r   <= '0;
                y_pos_r <= y_next_s;
                if (point_s) begin
                    tick_cnt_r <= '0;
                end else begin
                    tick_cnt_r <= tick_cnt_r + 1'b1;
                end
            end else if (run_s) begin
                ctr_r <= ctr_r + 1'b1;
            end
        end
    end

    // Saturating score with level progression; everything freezes once the score ceiling is reached
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score_r   <= '0;
            lvl_cnt_r <= '0;
            level_r   <= '0;
        end else if (grow_s) begin
            score_r <= score_r + 1'b1;
            if (lvl_wrap_s) begin
                lvl_cnt_r <= '0;
                if (level_r != LVL_CEIL) begin
                    level_r <= level_r + 1'b1;
                end
            end else begin
                lvl_cnt_r <= lvl_cnt_r + 1'b1;
            end
        end
    end

`ifdef SCROLL_BCD_EN
    logic [3:0] bcd_tens_r;
    logic [3:0] bcd_ones_r;

    // Decimal shadow of the score, stepped on the same edge as the binary score
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_tens_r <= 4'd0;
            bcd_ones_r <= 4'd0;
        end else if (grow_s) begin
            if (bcd_ones_r == 4'd9) begin
                bcd_ones_r <= 4'd0;
                bcd_tens_r <= bcd_tens_r + 4'd1;
            end else begin
                bcd_ones_r <= bcd_ones_r + 4'd1;
            end
        end
    end

    assign bus.score_bcd = {bcd_tens_r, bcd_ones_r};
`endif

    assign bus.y_pos          = y_pos_r;
    assign bus.score          = score_r;
    assign bus.level          = level_r;
    assign bus.move_followers = move_followers_r;
    assign bus.wrap           = wrap_r;
    assign bus.run_state      = state_r;
endmodule

// File: tb/tb_scroll_v_ctrl.sv
// Self-checking bench for scroll_v_ctrl: directed scenarios plus random move/pause/reset traffic
// checked every cycle against an arithmetic reference model (run-cycle count -> ticks -> score/level/position).
module tb_scroll_v_ctrl;
    localparam int Y_W   = 10;
    localparam int SH    = 16;
    localparam int TC    = 4;
    localparam int ST    = 2;
    localparam int SW    = 7;
    localparam int SMAX  = 5;
    localparam int SMIN  = 1;
    localparam int STMAX = 4;
    localparam int LUS   = 2;
    localparam int LVL_W = 2;
    localparam int LVLMAX = STMAX - SMIN;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HOLD  = 2;
    localparam int M_PAUSE = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    scroll_v_ctrl_if #(.Y_W(Y_W), .SCORE_W(SW), .LVL_W(LVL_W)) bus ();

    scroll_v_ctrl #(
        .Y_W(Y_W), .SCREEN_HEIGHT(SH), .TICK_CYCLES(TC), .SCORE_TICKS(ST),
        .SCORE_W(SW), .SCORE_MAX(SMAX), .STEP_MIN(SMIN), .STEP_MAX(STMAX),
        .LEVEL_UP_SCORE(LUS), .LVL_W(LVL_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks_cnt = 0;
    int errors_cnt = 0;

    int run_cnt, ticks, m_y, m_score, m_level, m_mf, m_wrap, m_state;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        run_cnt = 0; ticks = 0; m_y = 0; m_score = 0; m_level = 0;
        m_mf = 0; m_wrap = 0; m_state = M_IDLE;
    endtask

    // Everything follows from how many RUN cycles have elapsed since reset
    task automatic model_step(input logic mb, input logic ps);
        int sum;
        if (ps) m_state = M_PAUSE;
        else if (m_state == M_PAUSE) m_state = mb ? M_RUN : M_HOLD;
        else if (mb) m_state = M_RUN;
        else if (m_state == M_IDLE) m_state = M_IDLE;
        else m_state = M_HOLD;
        m_mf = 0;
        m_wrap = 0;
        if (mb && !ps) begin
            run_cnt++;
            if (run_cnt % TC == 0) begin
                sum = m_y + SMIN + m_level;
                m_mf = 1;
                m_wrap = (sum >= SH) ? 1 : 0;
                m_y = sum % SH;
                ticks++;
                m_score = (ticks / ST < SMAX) ? ticks / ST : SMAX;
                m_level = (m_score / LUS < LVLMAX) ? m_score / LUS : LVLMAX;
            end
        end
    endtask

    task automatic check_all();
        check_eq("y_pos", bus.y_pos, m_y);
        check_eq("score", bus.score, m_score);
        check_eq("level", bus.level, m_level);
        check_eq("move_followers", bus.move_followers, m_mf);
        check_eq("wrap", bus.wrap, m_wrap);
        check_eq("run_state", bus.run_state, m_state);
`ifdef SCROLL_BCD_EN
        check_eq("score_bcd", bus.score_bcd, (m_score / 10) * 16 + (m_score % 10));
`endif
    endtask

    task automatic cycle(input logic mb, input logic ps);
        bus.move_btn = mb;
        bus.pause = ps;
        @(posedge clk);
        model_step(mb, ps);
        #1;
        check_all();
    endtask

    // Called 1 time unit after an edge: pulls reset low between edges, checks the clear, then releases
    task automatic async_reset();
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check_all();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        bus.move_btn = 1'b0;
        bus.pause = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // Steady scrolling from reset: pulses on edges 4, 8, 12
        repeat (12) cycle(1'b1, 1'b0);
        check_eq("y_after_12", bus.y_pos, 32'd3);

        // Long run through level-ups, wrap and score saturation
        repeat (68) cycle(1'b1, 1'b0);
        check_eq("score_sat", bus.score, 32'd5);
        check_eq("level_sat", bus.level, 32'd2);

        // Reset mid-count with score 3, then first pulse four RUN cycles later
        async_reset();
        repeat (26) cycle(1'b1, 1'b0);
        check_eq("score_before_rst", bus.score, 32'd3);
        async_reset();
        repeat (3) cycle(1'b1, 1'b0);
        check_eq("no_pulse_early", bus.move_followers, 32'd0);
        cycle(1'b1, 1'b0);
        check_eq("pulse_after_rst", bus.move_followers, 32'd1);

        // Hold and pause retain the partial count
        async_reset();
        repeat (2) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        repeat (10) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        check_eq("no_pulse_resume1", bus.move_followers, 32'd0);
        cycle(1'b1, 1'b0);
        check_eq("pulse_resume2", bus.move_followers, 32'd1);

        // Random traffic with occasional resets
        repeat (600) begin
            if ($urandom_range(0, 199) == 0) async_reset();
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
